spi_target: RTL and testbench

//  SPI target (slave) endpoint for the QuantaRV SoC: the far end of the SPI controller, letting an external
//  SPI master exchange bytes with the CPU. SCLK/CS_N/MOSI are oversampled in the clk domain. Byte-wide RX/TX

---
 rtl/spi_pkg.sv | 26 ++
 rtl/spi_target_sync_fifo.sv | 62 ++++++
 rtl/spi_target.sv | 202 ++++++++++++++++++++
 tb/tb_spi_target.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target: register map, STATUS/CTRL bit
// positions and the frame state type.
package spi_pkg;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_CTRL   = 2'd1;
   localparam logic [1:0] REG_STATUS = 2'd2;
   localparam logic [1:0] REG_LEVEL  = 2'd3;

   localparam int ST_TX_FULL  = 0;
   localparam int ST_TX_EMPTY = 1;
   localparam int ST_RX_FULL  = 2;
   localparam int ST_RX_EMPTY = 3;
   localparam int ST_RX_OVF   = 4;
   localparam int ST_TX_UDR   = 5;

   localparam int CTRL_CPOL   = 0;
   localparam int CTRL_CPHA   = 1;
   localparam int CTRL_IRQ_EN = 2;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } spi_tgt_state_t;

endpackage

// File: rtl/spi_target_sync_fifo.sv
// Single-clock FIFO with registered pop data: dout shows the popped entry
// from the cycle after the pop. A push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == (AW+1)'(0));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // storage array write
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // pointers, occupancy and registered read data
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= {AW{1'b0}};
         rd_ptr <= {AW{1'b0}};
         count  <= {(AW+1){1'b0}};
         dout   <= {WIDTH{1'b0}};
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
            dout   <= mem[rd_ptr];
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/spi_target.sv
// SPI target endpoint: oversamples an external SPI master in the clk domain,
// moves bytes between the wire and RX/TX FIFOs, and exposes the FIFOs plus
// control/status to software through a Wishbone classic slave port.
module spi_target import spi_pkg::*; #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sclk_i,
   input  logic        cs_n_i,
   input  logic        mosi_i,
   output logic        miso_o,
   output logic        miso_oe_o,
   input  logic        cyc_i,
   input  logic        stb_i,
   input  logic        we_i,
   input  logic [3:0]  adr_i,
   input  logic [31:0] dat_i,
   output logic [31:0] dat_o,
   output logic        ack_o,
   output logic        err_o,
   output logic        irq_o
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [2:0] sclk_sync, cs_sync;
   logic [1:0] mosi_sync;
   logic sclk_rise, sclk_fall, cs_fall, cs_rise;
   logic lead_edge, trail_edge;
   spi_tgt_state_t state, next_state;
   logic start, in_frame, spi_sample, spi_shift, need_load;
   logic cpol_f, cpha_f, primed, load_pend, load_zero, load_drive, miso;
   logic [2:0] bit_cnt;
   logic [7:0] rx_shift, tx_shift, rx_din, load_byte;
   logic rx_push, rx_pop, rx_full, rx_empty, tx_push, tx_pop, tx_full, tx_empty;
   logic [7:0] rx_dout, tx_dout;
   logic [CW-1:0] rx_count, tx_count;
   logic ovf_set, udr_set, w1c_ovf, w1c_udr, req, rd_pending;
   logic [2:0] ctrl;
   logic rx_ovf, tx_udr;
   logic [31:0] dat_r, status, level;
   logic unused_bits;

   assign unused_bits = ^{adr_i[1:0], dat_i[31:8]};

   // two-flop synchronizers; the third sclk/cs flop only feeds edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync <= 3'b000;
         cs_sync   <= 3'b000;
         mosi_sync <= 2'b00;
      end else begin
         sclk_sync <= {sclk_sync[1:0], sclk_i};
         cs_sync   <= {cs_sync[1:0], cs_n_i};
         mosi_sync <= {mosi_sync[0], mosi_i};
      end
   end

   assign sclk_rise  = sclk_sync[1] & ~sclk_sync[2];
   assign sclk_fall  = ~sclk_sync[1] & sclk_sync[2];
   assign cs_fall    = ~cs_sync[1] & cs_sync[2];
   assign cs_rise    = cs_sync[1] & ~cs_sync[2];
   assign lead_edge  = cpol_f ? sclk_fall : sclk_rise;
   assign trail_edge = cpol_f ? sclk_rise : sclk_fall;

   // frame state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // frame state transitions: chip select alone opens and closes a frame
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (cs_fall) next_state = ACTIVE; else next_state = IDLE;
         ACTIVE:  if (cs_rise) next_state = IDLE;   else next_state = ACTIVE;
         default: next_state = IDLE;
      endcase
   end

   assign start      = (state == IDLE) & cs_fall;
   assign in_frame   = (state == ACTIVE) & ~cs_rise;
   assign spi_sample = in_frame & (cpha_f ? trail_edge : lead_edge);
   assign spi_shift  = in_frame & (cpha_f ? lead_edge : trail_edge);
   // a new TX byte is fetched at frame start and on the first shift edge of
   // each later byte; a CPHA=1 byte fetched at frame start is "primed"
   assign need_load  = start | (spi_shift & (bit_cnt == 3'd0) & ~primed);
   assign tx_pop     = need_load & ~tx_empty;
   assign udr_set    = need_load & tx_empty;
   assign rx_din     = {rx_shift[6:0], mosi_sync[1]};
   assign rx_push    = spi_sample & (bit_cnt == 3'd7) & (~rx_full | rx_pop);
   assign ovf_set    = spi_sample & (bit_cnt == 3'd7) & rx_full & ~rx_pop;
   assign load_byte  = load_zero ? 8'h00 : tx_dout;
   assign miso_o     = miso;
   assign miso_oe_o  = (state == ACTIVE);

   // bit engine: mode capture, shift registers, bit counter and MISO drive;
   // FIFO pop data lands one cycle after the pop, hence the load_pend stage
   always_ff @(posedge clk) begin
      if (rst) begin
         cpol_f <= 1'b0; cpha_f <= 1'b0; primed <= 1'b0;
         load_pend <= 1'b0; load_zero <= 1'b0; load_drive <= 1'b0;
         bit_cnt <= 3'd0; rx_shift <= 8'h00; tx_shift <= 8'h00; miso <= 1'b0;
      end else begin
         load_pend  <= need_load;
         load_zero  <= tx_empty;
         load_drive <= start ? ~ctrl[CTRL_CPHA] : 1'b1;
         if (start) begin
            cpol_f  <= ctrl[CTRL_CPOL];
            cpha_f  <= ctrl[CTRL_CPHA];
            primed  <= ctrl[CTRL_CPHA];
            bit_cnt <= 3'd0;
         end else if (spi_sample) begin
            rx_shift <= rx_din;
            bit_cnt  <= bit_cnt + 3'd1;
         end
         if (load_pend) begin
            if (load_drive) begin
               miso     <= load_byte[7];
               tx_shift <= {load_byte[6:0], 1'b0};
            end else begin
               tx_shift <= load_byte;
            end
         end else if (spi_shift & ~need_load) begin
            miso     <= tx_shift[7];
            tx_shift <= {tx_shift[6:0], 1'b0};
            primed   <= 1'b0;
         end
      end
   end

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .rst(rst), .push(rx_push), .din(rx_din), .pop(rx_pop),
      .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
   );

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .rst(rst), .push(tx_push), .din(dat_i[7:0]), .pop(tx_pop),
      .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
   );

   // a request is taken only when no response is on the bus this cycle
   assign req     = cyc_i & stb_i & ~ack_o & ~err_o;
   assign tx_push = req & we_i & (adr_i[3:2] == REG_DATA) & ~tx_full;
   assign rx_pop  = req & ~we_i & (adr_i[3:2] == REG_DATA) & ~rx_empty;
   assign w1c_ovf = req & we_i & (adr_i[3:2] == REG_STATUS) & dat_i[ST_RX_OVF];
   assign w1c_udr = req & we_i & (adr_i[3:2] == REG_STATUS) & dat_i[ST_TX_UDR];
   assign status  = {26'd0, tx_udr, rx_ovf, rx_empty, rx_full, tx_empty, tx_full};
   assign level   = {16'd0, 8'(tx_count), 8'(rx_count)};
   // popped RX data arrives from the FIFO's registered output with the ack
   assign dat_o   = rd_pending ? {24'd0, rx_dout} : dat_r;

   // Wishbone decode, control register, sticky flags and interrupt
   always_ff @(posedge clk) begin
      if (rst) begin
         ack_o <= 1'b0; err_o <= 1'b0; dat_r <= 32'd0; rd_pending <= 1'b0;
         ctrl <= 3'd0; rx_ovf <= 1'b0; tx_udr <= 1'b0; irq_o <= 1'b0;
      end else begin
         ack_o      <= 1'b0;
         err_o      <= 1'b0;
         dat_r      <= 32'd0;
         rd_pending <= 1'b0;
         rx_ovf     <= ovf_set | (rx_ovf & ~w1c_ovf);
         tx_udr     <= udr_set | (tx_udr & ~w1c_udr);
         irq_o      <= ctrl[CTRL_IRQ_EN] & (~rx_empty | rx_ovf | tx_udr);
         if (req) begin
            case (adr_i[3:2])
               REG_DATA: begin
                  if (we_i) begin
                     ack_o <= ~tx_full;
                     err_o <= tx_full;
                  end else begin
                     ack_o      <= ~rx_empty;
                     err_o      <= rx_empty;
                     rd_pending <= ~rx_empty;
                  end
               end
               REG_CTRL: begin
                  ack_o <= 1'b1;
                  if (we_i) ctrl <= dat_i[2:0];
                  else      dat_r <= {29'd0, ctrl};
               end
               REG_STATUS: begin
                  ack_o <= 1'b1;
                  if (!we_i) dat_r <= status;
               end
               REG_LEVEL: begin
                  ack_o <= 1'b1;
                  if (!we_i) dat_r <= level;
               end
               default: ack_o <= 1'b1;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: a bus-functional SPI master and
// Wishbone master, checked against a queue-based model of the FIFOs/flags.
module tb_spi_target;

   logic clk = 1'b0;
   logic rst, sclk, cs_n, mosi, cyc, stb, we;
   logic [3:0]  adr;
   logic [31:0] dat_w;
   logic        miso_o, miso_oe_o, ack_o, err_o, irq_o;
   logic [31:0] dat_o;

   always #5 clk = ~clk;

   spi_target #(.FIFO_DEPTH(8)) dut (
      .clk(clk), .rst(rst), .sclk_i(sclk), .cs_n_i(cs_n), .mosi_i(mosi),
      .miso_o(miso_o), .miso_oe_o(miso_oe_o), .cyc_i(cyc), .stb_i(stb),
      .we_i(we), .adr_i(adr), .dat_i(dat_w), .dat_o(dat_o), .ack_o(ack_o),
      .err_o(err_o), .irq_o(irq_o)
   );

   int n_total = 0;
   int n_bad   = 0;

   logic [7:0] tx_q [$];
   logic [7:0] rx_q [$];
   logic       exp_ovf, exp_udr;
   logic [7:0] m_out    [0:15];
   logic [7:0] m_in     [0:15];
   logic [7:0] exp_miso [0:15];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_status();
      return {26'd0, exp_udr, exp_ovf, rx_q.size() == 0, rx_q.size() == 8,
              tx_q.size() == 0, tx_q.size() == 8};
   endfunction

   function automatic logic [31:0] exp_level();
      return {16'd0, 8'(tx_q.size()), 8'(rx_q.size())};
   endfunction

   // one Wishbone access; response bounded to 4 cycles, then one idle cycle checked
   task automatic wb(input logic w, input logic [3:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic ak, output logic er);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d;
      ak = 1'b0; er = 1'b0; rd = 32'd0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (ack_o || err_o) begin
            ak = ack_o; er = err_o; rd = dat_o;
            break;
         end
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      if (!(ak || er)) check_eq("wb_timeout", 32'd0, 32'd1);
      @(negedge clk);
      check_eq("wb_single_pulse", {30'd0, ack_o, err_o}, 32'd0);
   endtask

   task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
      logic [31:0] rd; logic ak, er;
      wb(1'b1, a, d, rd, ak, er);
      check_eq("wr_ack", {30'd0, ak, er}, 32'd2);
   endtask

   task automatic rd_reg(input logic [3:0] a, output logic [31:0] d);
      logic ak, er;
      wb(1'b0, a, 32'd0, d, ak, er);
      check_eq("rd_ack", {30'd0, ak, er}, 32'd2);
   endtask

   task automatic push_tx(input logic [7:0] b);
      logic [31:0] rd; logic ak, er;
      wb(1'b1, 4'h0, {24'd0, b}, rd, ak, er);
      if (tx_q.size() < 8) begin
         check_eq("tx_push_ack", {30'd0, ak, er}, 32'd2);
         tx_q.push_back(b);
      end else begin
         check_eq("tx_push_err", {30'd0, ak, er}, 32'd1);
      end
   endtask

   task automatic pop_rx(output logic [31:0] d);
      logic ak, er;
      wb(1'b0, 4'h0, 32'd0, d, ak, er);
      if (rx_q.size() > 0) begin
         check_eq("rx_pop_ack", {30'd0, ak, er}, 32'd2);
         check_eq("rx_pop_data", d, {24'd0, rx_q.pop_front()});
      end else begin
         check_eq("rx_pop_err", {30'd0, ak, er}, 32'd1);
         check_eq("rx_pop_err_dat", d, 32'd0);
      end
   endtask

   task automatic check_status_level();
      logic [31:0] v;
      rd_reg(4'h8, v);
      check_eq("status", v, exp_status());
      rd_reg(4'hC, v);
      check_eq("level", v, exp_level());
   endtask

   // model: one TX fetch at CS fall, then one per byte boundary (CPHA=0:
   // trailing edge after every full byte; CPHA=1: start of each later byte)
   task automatic model_frame(input int nbytes, input int extra, input logic cpha);
      int npop, started;
      started = nbytes + ((extra > 0) ? 1 : 0);
      if (!cpha) npop = 1 + nbytes;
      else       npop = (started > 1) ? started : 1;
      for (int k = 0; k < npop; k++) begin
         if (tx_q.size() > 0) exp_miso[k] = tx_q.pop_front();
         else begin exp_miso[k] = 8'h00; exp_udr = 1'b1; end
      end
      for (int k = 0; k < nbytes; k++) begin
         if (rx_q.size() < 8) rx_q.push_back(m_out[k]);
         else exp_ovf = 1'b1;
      end
   endtask

   // SPI master: half period of 8 clk, MSB first, optional trailing partial byte
   task automatic spi_frame(input int nbytes, input int extra, input logic cpol, input logic cpha);
      int nb;
      sclk = cpol;
      repeat (4) @(negedge clk);
      cs_n = 1'b0;
      repeat (12) @(negedge clk);
      for (int b = 0; b < nbytes + ((extra > 0) ? 1 : 0); b++) begin
         nb = (b < nbytes) ? 8 : extra;
         for (int i = 7; i > 7 - nb; i--) begin
            if (!cpha) begin
               mosi = m_out[b][i];
               repeat (8) @(negedge clk);
               sclk = ~cpol; m_in[b][i] = miso_o;
               repeat (8) @(negedge clk);
               sclk = cpol;
            end else begin
               sclk = ~cpol; mosi = m_out[b][i];
               repeat (8) @(negedge clk);
               sclk = cpol; m_in[b][i] = miso_o;
               repeat (8) @(negedge clk);
            end
         end
      end
      repeat (8) @(negedge clk);
      cs_n = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   initial begin
      logic [31:0] v;
      int mode, npre, nbytes, extra;
      logic cpol, cpha;

      rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
      cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 4'h0; dat_w = 32'd0;
      exp_ovf = 1'b0; exp_udr = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_pins", {27'd0, miso_o, miso_oe_o, ack_o, err_o, irq_o}, 32'd0);
      check_eq("rst_dat", dat_o, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check_status_level();

      // mode 0 single byte exchange
      wr_reg(4'h4, 32'd0);
      push_tx(8'hA5);
      m_out[0] = 8'h3C;
      model_frame(1, 0, 1'b0);
      spi_frame(1, 0, 1'b0, 1'b0);
      check_eq("m0_miso", {24'd0, m_in[0]}, 32'hA5);
      pop_rx(v);
      check_eq("m0_rx", v, 32'h3C);
      wr_reg(4'h8, 32'h30); exp_udr = 1'b0; exp_ovf = 1'b0;

      // mode 3, three bytes with two queued -> underrun on the third
      wr_reg(4'h4, 32'd3);
      push_tx(8'h10); push_tx(8'h20);
      m_out[0] = 8'h01; m_out[1] = 8'h02; m_out[2] = 8'h03;
      model_frame(3, 0, 1'b1);
      spi_frame(3, 0, 1'b1, 1'b1);
      check_eq("m3_b0", {24'd0, m_in[0]}, 32'h10);
      check_eq("m3_b1", {24'd0, m_in[1]}, 32'h20);
      check_eq("m3_b2", {24'd0, m_in[2]}, 32'h00);
      rd_reg(4'h8, v);
      check_eq("m3_udr", {31'd0, v[5]}, 32'd1);
      check_status_level();
      for (int k = 0; k < 3; k++) pop_rx(v);
      wr_reg(4'h8, 32'h30); exp_udr = 1'b0;

      // nine bytes with no reads -> overflow, first eight intact
      wr_reg(4'h4, 32'd0);
      for (int k = 0; k < 9; k++) m_out[k] = 8'(8'h40 + 8'(k * 7));
      model_frame(9, 0, 1'b0);
      spi_frame(9, 0, 1'b0, 1'b0);
      rd_reg(4'h8, v);
      check_eq("ovf_flags", {30'd0, v[4], v[2]}, 32'd3);
      check_status_level();
      for (int k = 0; k < 8; k++) begin
         pop_rx(v);
         check_eq("ovf_keep", v, {24'd0, m_out[k]});
      end
      wr_reg(4'h8, 32'h10); exp_ovf = 1'b0;
      rd_reg(4'h8, v);
      check_eq("ovf_w1c", {31'd0, v[4]}, 32'd0);
      wr_reg(4'h8, 32'h20); exp_udr = 1'b0;

      // aborted frame after 5 bits, then a clean byte
      m_out[0] = 8'hF0;
      model_frame(0, 5, 1'b0);
      spi_frame(0, 5, 1'b0, 1'b0);
      rd_reg(4'hC, v);
      check_eq("abort_rx_lvl", {24'd0, v[7:0]}, 32'd0);
      m_out[0] = 8'h81;
      model_frame(1, 0, 1'b0);
      spi_frame(1, 0, 1'b0, 1'b0);
      pop_rx(v);
      check_eq("abort_next", v, 32'h81);
      wr_reg(4'h8, 32'h30); exp_udr = 1'b0; exp_ovf = 1'b0;

      // randomized frames in random modes
      for (int it = 0; it < 6; it++) begin
         mode = $urandom_range(3, 0);
         npre = $urandom_range(3, 0);
         nbytes = $urandom_range(3, 1);
         extra = ($urandom_range(3, 0) == 0) ? $urandom_range(7, 1) : 0;
         cpol = mode[0]; cpha = mode[1];
         wr_reg(4'h4, 32'(mode));
         for (int k = 0; k < npre; k++) push_tx(8'($urandom));
         for (int k = 0; k <= nbytes; k++) m_out[k] = 8'($urandom);
         model_frame(nbytes, extra, cpha);
         spi_frame(nbytes, extra, cpol, cpha);
         for (int k = 0; k < nbytes; k++) check_eq("rnd_miso", {24'd0, m_in[k]}, {24'd0, exp_miso[k]});
         check_status_level();
         while (rx_q.size() > 0) pop_rx(v);
         wr_reg(4'h8, 32'h30); exp_udr = 1'b0; exp_ovf = 1'b0;
      end

      // error responses: empty RX read, full TX write
      pop_rx(v);
      while (tx_q.size() < 8) push_tx(8'($urandom));
      push_tx(8'hEE);
      rd_reg(4'hC, v);
      check_eq("txfull_lvl", {24'd0, v[15:8]}, 32'd8);

      // reset in the middle of a frame
      sclk = 1'b0; cs_n = 1'b0;
      repeat (12) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         sclk = 1'b1; repeat (8) @(negedge clk);
         sclk = 1'b0; repeat (8) @(negedge clk);
      end
      check_eq("mid_oe", {31'd0, miso_oe_o}, 32'd1);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("midrst_pins", {27'd0, miso_o, miso_oe_o, ack_o, err_o, irq_o}, 32'd0);
      check_eq("midrst_dat", dat_o, 32'd0);
      rst = 1'b0;
      tx_q.delete(); rx_q.delete(); exp_ovf = 1'b0; exp_udr = 1'b0;
      repeat (10) @(negedge clk);
      check_eq("midrst_no_resume", {31'd0, miso_oe_o}, 32'd0);
      cs_n = 1'b1;
      repeat (10) @(negedge clk);
      check_status_level();

      // interrupt on received byte, cleared by draining RX
      wr_reg(4'h4, 32'd6);
      push_tx(8'h5A);
      m_out[0] = 8'h77;
      model_frame(1, 0, 1'b1);
      spi_frame(1, 0, 1'b0, 1'b1);
      check_eq("irq_miso", {24'd0, m_in[0]}, 32'h5A);
      check_eq("irq_set", {31'd0, irq_o}, 32'd1);
      pop_rx(v);
      check_eq("irq_rx", v, 32'h77);
      repeat (3) @(negedge clk);
      check_eq("irq_clr", {31'd0, irq_o}, 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
